// File: rtl/addpkg.sv
// addpkg: shared types and constants for the FP adder normalize stage.
//   fp_t     : packed IEEE-754 single {sign, exponent, frac}
//   state_t  : normalize-stage FSM states
//   FP_ZERO  : +0.0
//   FP_INF   : +Inf (caller sets the sign)
//   pack_fp  : builds an fp_t from its three fields
package addpkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam fp_t FP_ZERO = '{sign: 1'b0, exponent: {EXP_W{1'b0}}, frac: {FRAC_W{1'b0}}};
  localparam fp_t FP_INF  = '{sign: 1'b0, exponent: {EXP_W{1'b1}}, frac: {FRAC_W{1'b0}}};

  function automatic fp_t pack_fp(input logic              s,
                                  input logic [EXP_W-1:0]  e,
                                  input logic [FRAC_W-1:0] f);
    fp_t r;
    r.sign     = s;
    r.exponent = e;
    r.frac     = f;
    return r;
  endfunction

endpackage

// File: rtl/fp_add_normalize_lzc24.sv
// lzc24: 24-bit leading-zero counter used by the single-cycle normalize
// option (built only when FP_FAST_NORM_EN is defined).
//   in_i  [23:0] : value to scan
//   cnt_o [4:0]  : number of leading zeros (24 when in_i is zero)
`ifdef FP_FAST_NORM_EN
module lzc24 (
  input  logic [23:0] in_i,
  output logic [4:0]  cnt_o
);

  // Scan LSB to MSB so the highest set bit has the last word.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      cnt_o = in_i[i] ? 5'(23 - i) : cnt_o;
    end
  end

endmodule
`endif

// File: rtl/fp_add_normalize.sv
// fp_add_normalize: post-alignment add/subtract, normalize and pack stage of
// the FP adder. Truncating (no rounding), one operation in flight.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a                   : op A packed (larger exponent)
//   b_sign, b_sig       : aligned op B sign and 24-bit significand (hidden bit explicit)
//   out_valid/out_ready : result handshake, result held until accepted
//   result              : packed sum
// Configuration macro: FP_FAST_NORM_EN selects a single-cycle LZC-based
// normalize; otherwise normalize shifts one bit per cycle. Results match.
module fp_add_normalize
  import addpkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_t              a,
  input  logic             b_sign,
  input  logic [SIG_W-1:0] b_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_t              result
);

  state_t           state_q, state_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0] ma_q, ma_d;
  logic [SIG_W-1:0] mb_q, mb_d;
  logic [SIG_W-1:0] sum_q, sum_d;
  fp_t              result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [SIG_W:0]   add_s;
  logic             add_sign_s;
  logic [SIG_W-1:0] norm_sum_s;
  logic [EXP_W-1:0] norm_exp_s;
  logic             norm_done_s;

  // Signed-magnitude add: on unlike signs the larger magnitude supplies the sign.
  always_comb begin
    add_s      = {(SIG_W+1){1'b0}};
    add_sign_s = sign_a_q;
    if (sign_a_q == sign_b_q) begin
      add_s      = {1'b0, ma_q} + {1'b0, mb_q};
      add_sign_s = sign_a_q;
    end else if (ma_q >= mb_q) begin
      add_s      = {1'b0, ma_q - mb_q};
      add_sign_s = sign_a_q;
    end else begin
      add_s      = {1'b0, mb_q - ma_q};
      add_sign_s = sign_b_q;
    end
  end

`ifdef FP_FAST_NORM_EN
  logic [4:0]       lzc_s;
  logic [EXP_W-1:0] lzc_ext_s;
  logic [EXP_W-1:0] room_s;
  logic [EXP_W-1:0] shift_s;

  lzc24 u_lzc (
    .in_i  (sum_q),
    .cnt_o (lzc_s)
  );

  // Whole normalize in one step; the exponent cannot drop below 1, so a
  // shift limited by it leaves a denormal significand.
  always_comb begin
    lzc_ext_s   = EXP_W'(lzc_s);
    room_s      = exp_q - EXP_ONE;
    shift_s     = (lzc_ext_s < room_s) ? lzc_ext_s : room_s;
    norm_sum_s  = sum_q << shift_s;
    norm_exp_s  = exp_q - shift_s;
    norm_done_s = 1'b1;
  end
`else
  // One bit per cycle; stop once the leading one reaches bit 23 or e hits 1.
  always_comb begin
    norm_sum_s  = {sum_q[SIG_W-2:0], 1'b0};
    norm_exp_s  = exp_q - EXP_ONE;
    norm_done_s = norm_sum_s[FRAC_W] | (norm_exp_s == EXP_ONE);
  end
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sum_d    = sum_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_a_d = a.sign;
          // A zero exponent field is a denormal: scale as e=1, hidden bit 0.
          exp_d    = (a.exponent == {EXP_W{1'b0}}) ? EXP_ONE : a.exponent;
          ma_d     = {(a.exponent != {EXP_W{1'b0}}), a.frac};
          sign_b_d = b_sign;
          mb_d     = b_sig;
          state_d  = ADD;
        end else begin
          state_d  = IDLE;
        end
      end
      ADD: begin
        sign_d = add_sign_s;
        if (add_s == {(SIG_W+1){1'b0}}) begin
          result_d = FP_ZERO;
          state_d  = DONE;
        end else if (add_s[SIG_W]) begin
          // Carry out: one right shift; exponent overflow saturates to Inf.
          if (exp_q == (EXP_MAX - EXP_ONE)) begin
            result_d      = FP_INF;
            result_d.sign = add_sign_s;
          end else begin
            result_d = pack_fp(add_sign_s, exp_q + EXP_ONE, add_s[FRAC_W:1]);
          end
          state_d = DONE;
        end else if (add_s[FRAC_W]) begin
          result_d = pack_fp(add_sign_s, exp_q, add_s[FRAC_W-1:0]);
          state_d  = DONE;
        end else if (exp_q == EXP_ONE) begin
          // Already at the minimum exponent: no room to shift, result is denormal.
          result_d = pack_fp(add_sign_s, {EXP_W{1'b0}}, add_s[FRAC_W-1:0]);
          state_d  = DONE;
        end else begin
          sum_d   = add_s[SIG_W-1:0];
          state_d = NORM;
        end
      end
      NORM: begin
        sum_d = norm_sum_s;
        exp_d = norm_exp_s;
        if (norm_done_s) begin
          result_d = pack_fp(sign_q,
                             norm_sum_s[FRAC_W] ? norm_exp_s : {EXP_W{1'b0}},
                             norm_sum_s[FRAC_W-1:0]);
          state_d  = DONE;
        end else begin
          state_d  = NORM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= {EXP_W{1'b0}};
      ma_q        <= {SIG_W{1'b0}};
      mb_q        <= {SIG_W{1'b0}};
      sum_q       <= {SIG_W{1'b0}};
      result_q    <= FP_ZERO;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Self-checking bench for fp_add_normalize: directed operand vectors, an
// arithmetic reference model, and one negedge monitor that checks result,
// latency, hold-while-stalled and handshake behaviour.
module tb_fp_add_normalize;
  import addpkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fp_t         a;
  logic        b_sign;
  logic [23:0] b_sig;
  logic        out_valid;
  logic        out_ready;
  fp_t         result;

  int n_vec = 0;
  int n_err = 0;

  // monitor state
  bit          pending = 1'b0;
  bit          seen_valid = 1'b0;
  bit          hs_pend = 1'b0;
  int          lat = 0;
  logic [31:0] exp_res;
  int          exp_lat;

  fp_add_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b_sign    (b_sign),
    .b_sig     (b_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: signed integer sum of the two significands, then normalize
  // the magnitude with the exponent clamped at 1 and saturate at 255.
  function automatic void model(input logic [31:0] av, input logic bs, input logic [23:0] bm,
                                output logic [31:0] res, output int lat_o);
    int     e;
    longint ma, va, vb, t, mag;
    bit     sgn;
    int     shifts;
    e      = (av[30:23] == 8'd0) ? 1 : int'(av[30:23]);
    ma     = longint'({(av[30:23] != 8'd0), av[22:0]});
    va     = av[31] ? -ma : ma;
    vb     = bs ? -longint'(bm) : longint'(bm);
    t      = va + vb;
    shifts = 0;
    lat_o  = 2;
    if (t == 0) begin
      res = 32'h0;
      return;
    end
    sgn = (t < 0);
    mag = sgn ? -t : t;
    if (mag >= 64'd16777216) begin
      mag = mag >> 1;
      e   = e + 1;
    end
    if (e >= 255) begin
      res = {sgn, 8'hFF, 23'h0};
      return;
    end
    while (mag < 64'd8388608 && e > 1) begin
      mag    = mag << 1;
      e      = e - 1;
      shifts = shifts + 1;
    end
    res = {sgn, (mag >= 64'd8388608) ? 8'(e) : 8'h0, mag[22:0]};
`ifdef FP_FAST_NORM_EN
    lat_o = (shifts == 0) ? 2 : 3;
`else
    lat_o = 2 + shifts;
`endif
  endfunction

  // Single compare process: latency on first out_valid, value and stability
  // every valid cycle, ready/valid relationship around the handshake.
  always @(negedge clk) begin
    if (rst) begin
      pending    = 1'b0;
      seen_valid = 1'b0;
      hs_pend    = 1'b0;
    end else begin
      if (hs_pend) begin
        check(out_valid == 1'b0, "valid_after_accept", {31'd0, out_valid}, 32'd0);
        check(in_ready == 1'b1, "ready_after_accept", {31'd0, in_ready}, 32'd1);
        hs_pend    = 1'b0;
        pending    = 1'b0;
        seen_valid = 1'b0;
      end else if (pending) begin
        lat++;
        if (out_valid) begin
          if (!seen_valid) check(lat == exp_lat, "latency", 32'(lat), 32'(exp_lat));
          check(result == exp_res, "result", result, exp_res);
          check(in_ready == 1'b0, "ready_in_done", {31'd0, in_ready}, 32'd0);
          seen_valid = 1'b1;
          if (out_ready) hs_pend = 1'b1;
        end else if (seen_valid) begin
          check(1'b0, "valid_dropped", 32'd0, 32'd1);
          pending = 1'b0;
        end else if (lat > 40) begin
          check(1'b0, "result_timeout", 32'(lat), 32'(exp_lat));
          pending = 1'b0;
        end
      end else if (out_valid) begin
        check(1'b0, "spurious_valid", result, 32'h0);
      end
      if (in_valid && in_ready) begin
        model(a, b_sign, b_sig, exp_res, exp_lat);
        pending    = 1'b1;
        seen_valid = 1'b0;
        lat        = 0;
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic bs, input logic [23:0] bm);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check(1'b0, "in_ready_timeout", 32'd0, 32'd1);
    end else begin
      a        = av;
      b_sign   = bs;
      b_sig    = bm;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    while ((pending || !in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(!pending, "drain_timeout", {31'd0, pending}, 32'd0);
  endtask

  // Directed vectors: {a, b_sign, b_sig}
  typedef struct {
    logic [31:0] av;
    logic        bs;
    logic [23:0] bm;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] one_f;
    logic [31:0] r;
    int          l;

    one_f = {1'b0, 8'(BIAS), 23'h0};
    vecs[0]  = '{one_f,        1'b0, 24'h800000};  // 1+1 carry
    vecs[1]  = '{one_f,        1'b1, 24'h600000};  // 2 shifts
    vecs[2]  = '{one_f,        1'b1, 24'hC00000};  // sign from B
    vecs[3]  = '{one_f,        1'b1, 24'h800000};  // exact zero
    vecs[4]  = '{32'h7F7FFFFF, 1'b0, 24'hFFFFFF};  // overflow to Inf
    vecs[5]  = '{32'h00000010, 1'b0, 24'h000020};  // denormal + denormal
    vecs[6]  = '{32'h00800000, 1'b1, 24'h000001};  // min normal to denormal
    vecs[7]  = '{32'h01000000, 1'b1, 24'h7FFFFF};  // shift stops at e==1
    vecs[8]  = '{32'h40400000, 1'b1, 24'hBFFFFF};  // 23-shift cancellation
    vecs[9]  = '{32'hC0000000, 1'b1, 24'h800000};  // negative carry
    vecs[10] = '{32'hBF800000, 1'b0, 24'h400000};  // negative A minus B

    // Hand-computed pins on the reference model.
    model(vecs[0].av, vecs[0].bs, vecs[0].bm, r, l);
    check(r == 32'h40000000 && l == 2, "model_v0", r, 32'h40000000);
    model(vecs[1].av, vecs[1].bs, vecs[1].bm, r, l);
`ifdef FP_FAST_NORM_EN
    check(r == 32'h3E800000 && l == 3, "model_v1", r, 32'h3E800000);
`else
    check(r == 32'h3E800000 && l == 4, "model_v1", r, 32'h3E800000);
`endif
    model(vecs[2].av, vecs[2].bs, vecs[2].bm, r, l);
    check(r == 32'hBF000000, "model_v2", r, 32'hBF000000);
    model(vecs[3].av, vecs[3].bs, vecs[3].bm, r, l);
    check(r == 32'h00000000 && l == 2, "model_v3", r, 32'h00000000);
    model(vecs[4].av, vecs[4].bs, vecs[4].bm, r, l);
    check(r == 32'h7F800000, "model_v4", r, 32'h7F800000);
    model(vecs[7].av, vecs[7].bs, vecs[7].bm, r, l);
    check(r == 32'h00000002, "model_v7", r, 32'h00000002);
    model(vecs[8].av, vecs[8].bs, vecs[8].bm, r, l);
    check(r == 32'h34800000, "model_v8", r, 32'h34800000);
    model(vecs[9].av, vecs[9].bs, vecs[9].bm, r, l);
    check(r == 32'hC0800000, "model_v9", r, 32'hC0800000);

    // Reset state.
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = FP_ZERO;
    b_sign    = 1'b0;
    b_sig     = 24'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "reset_in_ready", {31'd0, in_ready}, 32'd1);
    check(out_valid == 1'b0, "reset_out_valid", {31'd0, out_valid}, 32'd0);
    check(result == 32'h0, "reset_result", result, 32'h0);

    // Directed vectors back to back with the consumer always ready.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].av, vecs[i].bs, vecs[i].bm);
      drain();
    end

    // Consumer stalls 5 cycles in DONE.
    out_ready = 1'b0;
    send(vecs[2].av, vecs[2].bs, vecs[2].bm);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check(out_valid == 1'b1, "stall_valid_seen", {31'd0, out_valid}, 32'd1);
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset while normalizing drops the op.
    send(vecs[8].av, vecs[8].bs, vecs[8].bm);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(out_valid == 1'b0, "abort_out_valid", {31'd0, out_valid}, 32'd0);
    check(result == 32'h0, "abort_result", result, 32'h0);
    check(in_ready == 1'b1, "abort_in_ready", {31'd0, in_ready}, 32'd1);

    // Next op after the abort completes normally.
    send(vecs[8].av, vecs[8].bs, vecs[8].bm);
    drain();
    send(vecs[1].av, vecs[1].bs, vecs[1].bm);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
